count_wrap_monitor: RTL and testbench

COUNT_WRAP_MONITOR -- requirements
Module: count_wrap_monitor

---
 rtl/count_wrap_monitor.sv | 148 ++++++++++++++
 tb/tb_count_wrap_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/count_wrap_monitor.sv
// Watches a 4-bit up/down counter for wraps and direction changes and queues
// timestamped event records in a small FIFO. Define WRAP_STAMP_EN for cycle stamps.
module count_wrap_monitor #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               q_in,
    input  logic                     mode_in,
    input  logic                     clr_ovf,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [15:0]              ev_data,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     overflow,
    output logic [7:0]               wrap_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [1:0] code;
        logic       mode;
        logic       rsvd;
        logic [3:0] q;
        logic [7:0] stamp;
    } ev_rec_t;

    localparam logic [1:0] CODE_UP   = 2'b01;
    localparam logic [1:0] CODE_DOWN = 2'b10;
    localparam logic [1:0] CODE_DIR  = 2'b11;

    logic          prime_q;
    logic [3:0]    q_prev_q;
    logic          mode_prev_q;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ev_valid_q, ev_valid_d;
    logic [15:0]   head_q,   head_d;
    logic          ovf_q,    ovf_d;
    logic [7:0]    wrap_q,   wrap_d;

    logic          up_wrap_c, down_wrap_c, dir_chg_c;
    logic          push_c, pop_c, full_c, push_ok_c;
    ev_rec_t       rec_c;
    logic [7:0]    stamp_c;

`ifdef WRAP_STAMP_EN
    logic [7:0] stamp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stamp_q <= 8'd0;
        else      stamp_q <= stamp_q + 8'd1;
    end

    assign stamp_c = stamp_q;
`else
    assign stamp_c = 8'd0;
`endif

    // Event detection; nothing fires until the previous-sample registers are primed
    assign up_wrap_c   = prime_q && (q_prev_q == 4'hF) && (q_in == 4'h0) &&  mode_in;
    assign down_wrap_c = prime_q && (q_prev_q == 4'h0) && (q_in == 4'hF) && !mode_in;
    assign dir_chg_c   = prime_q && (mode_in != mode_prev_q);
    assign push_c      = up_wrap_c || down_wrap_c || dir_chg_c;

    always_comb begin
        rec_c       = '0;
        rec_c.mode  = mode_in;
        rec_c.q     = q_in;
        rec_c.stamp = stamp_c;
        if (up_wrap_c)        rec_c.code = CODE_UP;
        else if (down_wrap_c) rec_c.code = CODE_DOWN;
        else                  rec_c.code = CODE_DIR;
    end

    assign pop_c     = ev_valid_q && ev_ready;
    assign full_c    = (count_q == CW'(DEPTH));
    assign push_ok_c = push_c && (!full_c || pop_c);

    // FIFO bookkeeping and the registered head-of-queue view
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        wrap_d     = wrap_q;
        head_d     = '0;
        ev_valid_d = 1'b0;

        if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_c)     rd_ptr_d = rd_ptr_q + AW'(1);

        if (push_ok_c && !pop_c)      count_d = count_q + CW'(1);
        else if (!push_ok_c && pop_c) count_d = count_q - CW'(1);

        if (push_c && full_c && !pop_c) ovf_d = 1'b1;
        else if (clr_ovf)               ovf_d = 1'b0;

        if ((up_wrap_c || down_wrap_c) && (wrap_q != 8'hFF)) wrap_d = wrap_q + 8'd1;

        // The slot being written this edge is only the next head when the queue was drained to it
        if (count_d != '0) begin
            ev_valid_d = 1'b1;
            if (push_ok_c && (wr_ptr_q == rd_ptr_d)) head_d = rec_c;
            else                                     head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prime_q     <= 1'b0;
            q_prev_q    <= 4'h0;
            mode_prev_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ev_valid_q  <= 1'b0;
            head_q      <= '0;
            ovf_q       <= 1'b0;
            wrap_q      <= 8'd0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            prime_q     <= 1'b1;
            q_prev_q    <= q_in;
            mode_prev_q <= mode_in;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ev_valid_q  <= ev_valid_d;
            head_q      <= head_d;
            ovf_q       <= ovf_d;
            wrap_q      <= wrap_d;
            if (push_ok_c) mem_q[wr_ptr_q] <= rec_c;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_data  = head_q;
    assign ev_count = count_q;
    assign overflow = ovf_q;
    assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Scoreboard bench for count_wrap_monitor: directed counter sequences queue expected
// records; a negedge monitor compares the FIFO head and retires entries on handshake.
module tb_count_wrap_monitor;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  q_in;
    logic        mode_in;
    logic        clr_ovf;
    logic        ev_valid;
    logic        ev_ready;
    logic [15:0] ev_data;
    logic [2:0]  ev_count;
    logic        overflow;
    logic [7:0]  wrap_cnt;

    int          vectors     = 0;
    int          miscompares = 0;
    int          edges       = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    count_wrap_monitor #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .q_in     (q_in),
        .mode_in  (mode_in),
        .clr_ovf  (clr_ovf),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_data  (ev_data),
        .ev_count (ev_count),
        .overflow (overflow),
        .wrap_cnt (wrap_cnt)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_stamp();
`ifdef WRAP_STAMP_EN
        return 8'(edges);
`else
        return 8'd0;
`endif
    endfunction

    // One clock of stimulus; when ev is set the record this edge must produce is queued
    task automatic step(input logic [3:0] q, input logic m, input bit ev, input logic [1:0] code);
        q_in    = q;
        mode_in = m;
        if (ev) sb.push_back({code, m, 1'b0, q, exp_stamp()});
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},    16'(ev_valid), 16'h0);
        chk({tag, "_data"},     ev_data,       16'h0);
        chk({tag, "_count"},    16'(ev_count), 16'h0);
        chk({tag, "_overflow"}, 16'(overflow), 16'h0);
        chk({tag, "_wrap_cnt"}, 16'(wrap_cnt), 16'h0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && ev_valid === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL head_unexpected: got %h expected no entry at %0t", ev_data, $time);
            end else begin
                chk("head", ev_data, sb[0]);
                if (ev_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst      = 1'b0;
        q_in     = 4'h0;
        mode_in  = 1'b0;
        clr_ovf  = 1'b0;
        ev_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");

        @(negedge clk);
        rst   = 1'b1;
        edges = 0;

        // Count up through 15 and wrap to 0
        for (int i = 0; i < 16; i++) step(4'(i), 1'b1, 1'b0, 2'b00);
        step(4'h0, 1'b1, 1'b1, 2'b01);
        chk("upwrap_count", 16'(ev_count), 16'd1);
        chk("upwrap_hi",    16'(ev_data[15:8]), 16'h0060);
        chk("upwrap_wraps", 16'(wrap_cnt), 16'd1);
        ev_ready = 1'b1;
        step(4'h0, 1'b1, 1'b0, 2'b00);
        chk("upwrap_drained", 16'(ev_count), 16'd0);

        // Direction change, down-wrap, and wraps coinciding with a direction change
        step(4'h5, 1'b1, 1'b0, 2'b00);
        step(4'h5, 1'b0, 1'b1, 2'b11);
        step(4'h1, 1'b0, 1'b0, 2'b00);
        step(4'h0, 1'b0, 1'b0, 2'b00);
        step(4'hF, 1'b0, 1'b1, 2'b10);
        step(4'h0, 1'b1, 1'b1, 2'b01);
        step(4'hF, 1'b0, 1'b1, 2'b10);
        step(4'hF, 1'b0, 1'b0, 2'b00);
        chk("dir_wraps", 16'(wrap_cnt), 16'd4);
        chk("dir_count", 16'(ev_count), 16'd0);

        // Fill with DEPTH+1 events while stalled
        ev_ready = 1'b0;
        step(4'h3, 1'b1, 1'b1, 2'b11);
        step(4'h3, 1'b0, 1'b1, 2'b11);
        step(4'h3, 1'b1, 1'b1, 2'b11);
        step(4'h3, 1'b0, 1'b1, 2'b11);
        step(4'h3, 1'b1, 1'b0, 2'b00);
        chk("full_count", 16'(ev_count), 16'd4);
        chk("full_ovf",   16'(overflow), 16'd1);
        clr_ovf = 1'b1;
        step(4'h3, 1'b1, 1'b0, 2'b00);
        clr_ovf = 1'b0;
        chk("clr_ovf",       16'(overflow), 16'd0);
        chk("clr_ovf_count", 16'(ev_count), 16'd4);

        // Full queue with simultaneous push and pop
        ev_ready = 1'b1;
        step(4'h3, 1'b0, 1'b1, 2'b11);
        ev_ready = 1'b0;
        chk("pushpop_count", 16'(ev_count), 16'd4);
        chk("pushpop_ovf",   16'(overflow), 16'd0);

        // Drops while clearing: overflow wins, dropped wrap still counted
        clr_ovf = 1'b1;
        step(4'hF, 1'b1, 1'b0, 2'b00);
        step(4'h0, 1'b1, 1'b0, 2'b00);
        clr_ovf = 1'b0;
        chk("clr_vs_ovf",    16'(overflow), 16'd1);
        chk("drop_wraps",    16'(wrap_cnt), 16'd5);
        chk("drop_count",    16'(ev_count), 16'd4);

        ev_ready = 1'b1;
        repeat (4) step(4'h0, 1'b1, 1'b0, 2'b00);
        chk("drain_count", 16'(ev_count), 16'd0);
        step(4'h0, 1'b1, 1'b0, 2'b00);
        chk("empty_pop_count", 16'(ev_count), 16'd0);
        chk("empty_pop_valid", 16'(ev_valid), 16'd0);

        // Reset in the middle of traffic
        ev_ready = 1'b0;
        step(4'h0, 1'b0, 1'b1, 2'b11);
        step(4'h0, 1'b1, 1'b1, 2'b11);
        chk("pre_reset_count", 16'(ev_count), 16'd2);
        rst = 1'b0;
        #2;
        chk_all_zero("midreset");
        sb.delete();
        @(negedge clk);
        rst   = 1'b1;
        edges = 0;
        step(4'hF, 1'b0, 1'b0, 2'b00);
        chk("unprimed_count", 16'(ev_count), 16'd0);
        chk("unprimed_wraps", 16'(wrap_cnt), 16'd0);

        // Up-wrap on the 20th edge after release
        repeat (17) step(4'h7, 1'b0, 1'b0, 2'b00);
        step(4'hF, 1'b0, 1'b0, 2'b00);
        step(4'h0, 1'b1, 1'b1, 2'b01);
`ifdef WRAP_STAMP_EN
        chk("stamp", 16'(ev_data[7:0]), 16'd19);
`else
        chk("stamp", 16'(ev_data[7:0]), 16'd0);
`endif
        chk("stamp_hi", 16'(ev_data[15:8]), 16'h0060);
        ev_ready = 1'b1;
        step(4'h0, 1'b1, 1'b0, 2'b00);

        // Saturate the wrap counter
        for (int i = 0; i < 256; i++) begin
            step(4'hF, 1'b1, 1'b0, 2'b00);
            step(4'h0, 1'b1, 1'b1, 2'b01);
        end
        step(4'h0, 1'b1, 1'b0, 2'b00);
        chk("wrap_saturate", 16'(wrap_cnt), 16'd255);
        chk("final_count",   16'(ev_count), 16'd0);
        chk("sb_retired",    16'(sb.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
